// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: queues fetch-stage predictions, resolves them against EXEC outcomes,
// feeds the predictor and issues redirect/flush on mispredicts. Optional stats via BRU_STATS_EN.
module branch_resolve_unit #(
    parameter int DEPTH        = 4,
    parameter int FLUSH_CYCLES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        f_push,
    input  logic [31:0] f_pc,
    input  logic        f_pred_taken,
    input  logic [31:0] f_pred_addr,
    output logic        f_full,
    input  logic        x_valid,
    input  logic        x_is_branch,
    input  logic        x_taken,
    input  logic [31:0] x_target,
    output logic        fb_valid,
    output logic        fb_taken,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic        underflow_err,
    output logic [31:0] br_count,
    output logic [31:0] mp_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [0:0] {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_e;

    state_e        state_q, state_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          fb_valid_q, fb_valid_d, fb_taken_q, fb_taken_d;
    logic          redirect_valid_q, redirect_valid_d;
    logic [31:0]   redirect_pc_q, redirect_pc_d;
    logic          underflow_q, underflow_d;

    logic [31:0]   pc_mem   [DEPTH];
    logic          pt_mem   [DEPTH];
    logic [31:0]   addr_mem [DEPTH];

    logic          full_s, run_s, pop_s, push_s, wr_en_s, mispredict_s;
    logic [31:0]   head_pc_s, head_addr_s, correct_pc_s;
    logic          head_taken_s;

    assign full_s       = (cnt_q == CW'(DEPTH));
    assign run_s        = (state_q == ST_RUN);
    assign pop_s        = run_s && x_valid && (cnt_q != {CW{1'b0}});
    // A pop in the same cycle frees a slot, so a full queue still accepts the push.
    assign push_s       = run_s && f_push && !redirect_valid_q && (!full_s || pop_s);
    assign head_pc_s    = pc_mem[rd_q];
    assign head_taken_s = pt_mem[rd_q];
    assign head_addr_s  = addr_mem[rd_q];
    assign mispredict_s = x_is_branch ? ((x_taken != head_taken_s) ||
                                         (x_taken && (x_target != head_addr_s)))
                                      : head_taken_s;
    assign correct_pc_s = (x_is_branch && x_taken) ? x_target : (head_pc_s + 32'd4);
    assign wr_en_s      = push_s && !(pop_s && mispredict_s);

    // Prediction storage; contents need no reset since pointers and count gate every read.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            pc_mem[wr_q]   <= f_pc;
            pt_mem[wr_q]   <= f_pred_taken;
            addr_mem[wr_q] <= f_pred_addr;
        end
    end

    // Next-state: queue bookkeeping, resolve strobes and RUN/FLUSH sequencing.
    always_comb begin
        state_d          = state_q;
        fcnt_d           = fcnt_q;
        rd_d             = rd_q;
        wr_d             = wr_q;
        cnt_d            = cnt_q;
        fb_valid_d       = pop_s && x_is_branch;
        fb_taken_d       = pop_s && x_is_branch && x_taken;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        underflow_d      = underflow_q | (run_s && x_valid && (cnt_q == {CW{1'b0}}));
        case (state_q)
            ST_RUN: begin
                if (pop_s && mispredict_s) begin
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = correct_pc_s;
                    rd_d             = {AW{1'b0}};
                    wr_d             = {AW{1'b0}};
                    cnt_d            = {CW{1'b0}};
                    state_d          = ST_FLUSH;
                    fcnt_d           = FW'(FLUSH_CYCLES - 1);
                end else begin
                    rd_d  = rd_q + AW'(pop_s);
                    wr_d  = wr_q + AW'(push_s);
                    cnt_d = cnt_q + CW'(push_s) - CW'(pop_s);
                end
            end
            ST_FLUSH: begin
                if (fcnt_q == {FW{1'b0}}) begin
                    state_d = ST_RUN;
                end else begin
                    fcnt_d = fcnt_q - FW'(1'b1);
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= ST_RUN;
            fcnt_q           <= {FW{1'b0}};
            rd_q             <= {AW{1'b0}};
            wr_q             <= {AW{1'b0}};
            cnt_q            <= {CW{1'b0}};
            fb_valid_q       <= 1'b0;
            fb_taken_q       <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'h0;
            underflow_q      <= 1'b0;
        end else begin
            state_q          <= state_d;
            fcnt_q           <= fcnt_d;
            rd_q             <= rd_d;
            wr_q             <= wr_d;
            cnt_q            <= cnt_d;
            fb_valid_q       <= fb_valid_d;
            fb_taken_q       <= fb_taken_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            underflow_q      <= underflow_d;
        end
    end

    assign f_full         = full_s;
    assign fb_valid       = fb_valid_q;
    assign fb_taken       = fb_taken_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign flush          = (state_q == ST_FLUSH);
    assign underflow_err  = underflow_q;

`ifdef BRU_STATS_EN
    logic [31:0] br_cnt_q, mp_cnt_q;

    // Saturating resolve/mispredict counters, aligned with the feedback/redirect strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            br_cnt_q <= 32'h0;
            mp_cnt_q <= 32'h0;
        end else begin
            if (pop_s && x_is_branch && (br_cnt_q != 32'hFFFF_FFFF)) begin
                br_cnt_q <= br_cnt_q + 32'd1;
            end
            if (pop_s && mispredict_s && (mp_cnt_q != 32'hFFFF_FFFF)) begin
                mp_cnt_q <= mp_cnt_q + 32'd1;
            end
        end
    end

    assign br_count = br_cnt_q;
    assign mp_count = mp_cnt_q;
`else
    assign br_count = 32'h0;
    assign mp_count = 32'h0;
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a queue-based behavioural model.
module tb_branch_resolve_unit;
    localparam int DEPTH = 4;
    localparam int FLUSH_CYCLES = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        f_push, f_pred_taken, x_valid, x_is_branch, x_taken;
    logic [31:0] f_pc, f_pred_addr, x_target;
    logic        f_full, fb_valid, fb_taken, redirect_valid, flush, underflow_err;
    logic [31:0] redirect_pc, br_count, mp_count;

    branch_resolve_unit #(.DEPTH(DEPTH), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
        .clk(clk), .reset(reset),
        .f_push(f_push), .f_pc(f_pc), .f_pred_taken(f_pred_taken), .f_pred_addr(f_pred_addr),
        .f_full(f_full),
        .x_valid(x_valid), .x_is_branch(x_is_branch), .x_taken(x_taken), .x_target(x_target),
        .fb_valid(fb_valid), .fb_taken(fb_taken),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .flush(flush), .underflow_err(underflow_err),
        .br_count(br_count), .mp_count(mp_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    typedef struct {
        logic [31:0] pc;
        bit          pt;
        logic [31:0] pa;
    } ent_t;

    ent_t        q[$];
    int          flush_left;
    bit          m_fbv, m_fbt, m_rv, m_uf;
    logic [31:0] m_rpc, m_br, m_mp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        q.delete();
        flush_left = 0;
        m_fbv = 1'b0; m_fbt = 1'b0; m_rv = 1'b0; m_uf = 1'b0;
        m_rpc = 32'h0; m_br = 32'h0; m_mp = 32'h0;
    endfunction

    // Advance the model by one clock using the inputs currently driven.
    function automatic void model_step();
        bit   run, pop, push, mp;
        ent_t e, n;
        run  = (flush_left == 0);
        pop  = run && x_valid && (q.size() > 0);
        push = run && f_push && ((q.size() < DEPTH) || pop);
        if (run && x_valid && (q.size() == 0)) m_uf = 1'b1;
        m_fbv = pop && x_is_branch;
        m_fbt = m_fbv && x_taken;
        m_rv  = 1'b0;
        mp    = 1'b0;
        if (flush_left > 0) flush_left--;
        if (pop) begin
            e = q.pop_front();
            if (x_is_branch) mp = (x_taken != e.pt) || (x_taken && (x_target != e.pa));
            else             mp = e.pt;
`ifdef BRU_STATS_EN
            if (x_is_branch && (m_br != 32'hFFFF_FFFF)) m_br = m_br + 32'd1;
            if (mp && (m_mp != 32'hFFFF_FFFF)) m_mp = m_mp + 32'd1;
`endif
            if (mp) begin
                m_rv  = 1'b1;
                m_rpc = (x_is_branch && x_taken) ? x_target : (e.pc + 32'd4);
                q.delete();
                flush_left = FLUSH_CYCLES;
            end
        end
        if (push && !mp) begin
            n.pc = f_pc; n.pt = f_pred_taken; n.pa = f_pred_addr;
            q.push_back(n);
        end
    endfunction

    // Compare every DUT output with the model shortly after each rising edge.
    always @(posedge clk) begin
        if (chk_en) begin
            #1;
            chk("cmp_full",     f_full,         32'(q.size() == DEPTH));
            chk("cmp_fbv",      fb_valid,       32'(m_fbv));
            chk("cmp_fbt",      fb_taken,       32'(m_fbt));
            chk("cmp_rv",       redirect_valid, 32'(m_rv));
            chk("cmp_rpc",      redirect_pc,    m_rpc);
            chk("cmp_flush",    flush,          32'(flush_left > 0));
            chk("cmp_uf",       underflow_err,  32'(m_uf));
            chk("cmp_br_count", br_count,       m_br);
            chk("cmp_mp_count", mp_count,       m_mp);
        end
    end

    task automatic idle_inputs();
        f_push = 1'b0; f_pc = 32'h0; f_pred_taken = 1'b0; f_pred_addr = 32'h0;
        x_valid = 1'b0; x_is_branch = 1'b0; x_taken = 1'b0; x_target = 32'h0;
    endtask

    task automatic step(input bit p, input logic [31:0] pc, input bit pt, input logic [31:0] pa,
                        input bit xv, input bit br, input bit tk, input logic [31:0] tg);
        @(negedge clk);
        f_push = p; f_pc = pc; f_pred_taken = pt; f_pred_addr = pa;
        x_valid = xv; x_is_branch = br; x_taken = tk; x_target = tg;
        model_step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic push(input logic [31:0] pc, input bit pt, input logic [31:0] pa);
        step(1'b1, pc, pt, pa, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic pop(input bit br, input bit tk, input logic [31:0] tg);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, br, tk, tg);
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    logic [31:0] exp_mp1;

    initial begin
        reset = 1'b1;
        idle_inputs();
        model_reset();
`ifdef BRU_STATS_EN
        exp_mp1 = 32'd1;
`else
        exp_mp1 = 32'd0;
`endif
        do_reset();
        chk_en = 1'b1;
        #1;
        chk("rst_full", f_full, 32'd0);
        chk("rst_rv", redirect_valid, 32'd0);
        chk("rst_rpc", redirect_pc, 32'd0);
        chk("rst_flush", flush, 32'd0);
        chk("rst_uf", underflow_err, 32'd0);

        // Correct taken prediction
        push(32'h100, 1'b1, 32'h200);
        pop(1'b1, 1'b1, 32'h200);
        chk("t1_fbv", fb_valid, 32'd1);
        chk("t1_fbt", fb_taken, 32'd1);
        chk("t1_rv", redirect_valid, 32'd0);

        // Direction mispredict: redirect and 3-cycle flush
        do_reset();
        push(32'h100, 1'b0, 32'h0);
        pop(1'b1, 1'b1, 32'h300);
        chk("t2_rv", redirect_valid, 32'd1);
        chk("t2_rpc", redirect_pc, 32'h300);
        chk("t2_flush0", flush, 32'd1);
        idle();
        chk("t2_rv_off", redirect_valid, 32'd0);
        chk("t2_flush1", flush, 32'd1);
        idle();
        chk("t2_flush2", flush, 32'd1);
        idle();
        chk("t2_flush3", flush, 32'd0);
        chk("t2_rpc_hold", redirect_pc, 32'h300);

        // Non-branch predicted taken
        do_reset();
        push(32'h40, 1'b1, 32'h80);
        pop(1'b0, 1'b0, 32'h0);
        chk("t3_fbv", fb_valid, 32'd0);
        chk("t3_rv", redirect_valid, 32'd1);
        chk("t3_rpc", redirect_pc, 32'h44);
        chk("t3_mp", mp_count, exp_mp1);
        repeat (3) idle();

        // Full queue, dropped push, push+pop while full, in-order pops, underflow
        do_reset();
        for (int i = 0; i < 4; i++) push(32'h1000 + 32'(16 * i), 1'b1, 32'h2000 + 32'(16 * i));
        chk("t4_full", f_full, 32'd1);
        push(32'hDEAD0, 1'b1, 32'hDEAD0);
        chk("t4_full_drop", f_full, 32'd1);
        step(1'b1, 32'h1040, 1'b1, 32'h2040, 1'b1, 1'b1, 1'b1, 32'h2000);
        chk("t4_full_pp", f_full, 32'd1);
        chk("t4_pp_rv", redirect_valid, 32'd0);
        for (int i = 1; i < 5; i++) begin
            pop(1'b1, 1'b1, 32'h2000 + 32'(16 * i));
            chk("t4_order_rv", redirect_valid, 32'd0);
        end
        chk("t4_empty", f_full, 32'd0);
        pop(1'b1, 1'b0, 32'h0);
        chk("t4_uf", underflow_err, 32'd1);
        idle();
        chk("t4_uf_sticky", underflow_err, 32'd1);

        // Reset in the middle of a flush
        do_reset();
        push(32'h100, 1'b0, 32'h0);
        pop(1'b1, 1'b1, 32'h300);
        @(negedge clk);
        idle_inputs();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("t5_flush", flush, 32'd0);
        chk("t5_rv", redirect_valid, 32'd0);
        chk("t5_rpc", redirect_pc, 32'd0);
        chk("t5_fbv", fb_valid, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // PC wrap on fall-through
        do_reset();
        push(32'hFFFF_FFFC, 1'b1, 32'h10);
        pop(1'b1, 1'b0, 32'h0);
        chk("t6_rv", redirect_valid, 32'd1);
        chk("t6_rpc", redirect_pc, 32'h0);
        repeat (3) idle();

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] pc, pa, tg;
            pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
            pa = ($urandom_range(0, 1) == 1) ? 32'h200 : 32'h300;
            tg = ($urandom_range(0, 1) == 1) ? 32'h200 : 32'h300;
            step(($urandom_range(0, 9) < 6), pc, 1'($urandom_range(0, 1)), pa,
                 ($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 7),
                 1'($urandom_range(0, 1)), tg);
            if ((n % 700) == 699) do_reset();
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
